// File: rtl/keypad_timer_entry_pkg.sv
// Shared definitions for the keypad timer-entry path: FSM states, key/BCD widths
// and the small combinational helpers used on the registered key vector.
package keypad_timer_entry_pkg;

    localparam int BCD_W = 4;
    localparam int NKEYS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_ACCEPT,
        ST_RELEASE
    } state_t;

    function automatic logic [BCD_W-1:0] key_to_bcd(input logic [NKEYS-1:0] keys);
        logic [BCD_W-1:0] bcd;
        bcd = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (keys[i]) begin
                bcd = BCD_W'(i);
            end
        end
        return bcd;
    endfunction

    function automatic logic is_one_hot(input logic [NKEYS-1:0] keys);
        return (keys != '0) && ((keys & (keys - NKEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/keypad_timer_entry_tick_divider.sv
// Countdown tick generator: while run is high, tick is asserted on the last count of
// each CLK_DIV-cycle period; dropping run restarts the period from zero.
module tick_divider #(
    parameter int CLK_DIV = 100
) (
    input  logic clock,
    input  logic clearn,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg + CW'(1);
        if (!run || (count_reg == LAST)) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!clearn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick = run && (count_reg == LAST);

endmodule

// File: rtl/keypad_timer_entry.sv
// Keypad timer entry: debounces the decimal pad, shifts accepted BCD digits into the
// time register with a one-cycle loadn strobe, and muxes the countdown/load tick.
module keypad_timer_entry
    import keypad_timer_entry_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int CLK_DIV  = 100,
    parameter int DEBOUNCE = 4
) (
    input  logic                     clock,
    input  logic                     clearn,
    input  logic [NKEYS-1:0]         tecladoNum,
    input  logic                     enable,
    output logic [BCD_W-1:0]         d,
    output logic                     loadn,
    output logic [BCD_W*NDIGITS-1:0] digits,
    output logic                     key_err,
    output logic                     pgt_1hz
);

    localparam int DW = BCD_W * NDIGITS;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);

    state_t           state_reg, state_next;
    logic [NKEYS-1:0] key_q_reg, key_prev_reg;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [BCD_W-1:0] d_reg, d_next;
    logic             loadn_reg, loadn_next;
    logic [DW-1:0]    digits_reg, digits_next;
    logic             key_err_reg, key_err_next;
    logic             pgt_reg, pgt_next;
    logic             div_tick;
    logic [BCD_W-1:0] key_bcd;
    logic [DW-1:0]    digits_shifted;

    tick_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_divider (
        .clock  (clock),
        .clearn (clearn),
        .run    (enable),
        .tick   (div_tick)
    );

    assign key_bcd = key_to_bcd(key_q_reg);

    // Newest digit enters at the bottom; the top digit falls off.
    assign digits_shifted[BCD_W-1:0] = key_bcd;
    generate
        for (genvar gi = 1; gi < NDIGITS; gi++) begin : g_shift
            assign digits_shifted[BCD_W*gi +: BCD_W] = digits_reg[BCD_W*(gi-1) +: BCD_W];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        d_next       = d_reg;
        loadn_next   = 1'b1;
        digits_next  = digits_reg;
        key_err_next = 1'b0;
        // In entry mode the tick doubles as the load clock one cycle after the strobe.
        pgt_next     = enable ? div_tick : (state_reg == ST_ACCEPT);

        if (enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (key_q_reg != '0) begin
                        state_next = ST_DEBOUNCE;
                        cnt_next   = CW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (key_q_reg != key_prev_reg) begin
                        if (key_q_reg == '0) begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = CW'(1);
                        end
                    end else if (cnt_reg == DB_MAX) begin
                        cnt_next = '0;
                        if (is_one_hot(key_q_reg)) begin
                            state_next  = ST_ACCEPT;
                            loadn_next  = 1'b0;
                            d_next      = key_bcd;
                            digits_next = digits_shifted;
                        end else begin
                            state_next   = ST_RELEASE;
                            key_err_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                ST_ACCEPT: begin
                    state_next = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (key_q_reg == '0) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!clearn) begin
            state_reg    <= ST_IDLE;
            key_q_reg    <= '0;
            key_prev_reg <= '0;
            cnt_reg      <= '0;
            d_reg        <= '0;
            loadn_reg    <= 1'b1;
            digits_reg   <= '0;
            key_err_reg  <= 1'b0;
            pgt_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            key_q_reg    <= tecladoNum;
            key_prev_reg <= key_q_reg;
            cnt_reg      <= cnt_next;
            d_reg        <= d_next;
            loadn_reg    <= loadn_next;
            digits_reg   <= digits_next;
            key_err_reg  <= key_err_next;
            pgt_reg      <= pgt_next;
        end
    end

    assign d       = d_reg;
    assign loadn   = loadn_reg;
    assign digits  = digits_reg;
    assign key_err = key_err_reg;
    assign pgt_1hz = pgt_reg;

endmodule

// File: tb/tb_keypad_timer_entry.sv
// Directed bench for keypad_timer_entry: table of key presses plus hand-written
// sequences for latency, bounce, enable/divider and reset-mid-press.
module tb_keypad_timer_entry;

    logic        clock = 1'b0;
    logic        clearn;
    logic [9:0]  tecladoNum;
    logic        enable;
    logic [3:0]  d;
    logic        loadn;
    logic [15:0] digits;
    logic        key_err;
    logic        pgt_1hz;

    int vec_cnt = 0;
    int err_cnt = 0;

    keypad_timer_entry #(
        .NDIGITS  (4),
        .CLK_DIV  (100),
        .DEBOUNCE (4)
    ) dut (
        .clock      (clock),
        .clearn     (clearn),
        .tecladoNum (tecladoNum),
        .enable     (enable),
        .d          (d),
        .loadn      (loadn),
        .digits     (digits),
        .key_err    (key_err),
        .pgt_1hz    (pgt_1hz)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  key;
        int          hold;
        int          gap;
        int          exp_loads;
        int          exp_errs;
        int          exp_pgts;
        logic [3:0]  exp_d;
        logic [15:0] exp_digits;
    } press_t;

    press_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick_sample();
        @(posedge clock);
        #1;
    endtask

    int loads, errs, pgts;

    task automatic count_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick_sample();
            if (loadn === 1'b0) loads++;
            if (key_err === 1'b1) errs++;
            if (pgt_1hz === 1'b1) pgts++;
        end
    endtask

    initial begin
        tbl[0] = '{10'b00_0000_0010, 10, 4, 1, 0, 1, 4'd1, 16'h0071};
        tbl[1] = '{10'b00_0000_0100, 10, 4, 1, 0, 1, 4'd2, 16'h0712};
        tbl[2] = '{10'b00_0000_1000, 10, 4, 1, 0, 1, 4'd3, 16'h7123};
        tbl[3] = '{10'b00_0001_0000, 10, 4, 1, 0, 1, 4'd4, 16'h1234};
        tbl[4] = '{10'b00_0010_0000, 10, 4, 1, 0, 1, 4'd5, 16'h2345};
        tbl[5] = '{10'b00_0010_0100, 12, 4, 0, 1, 0, 4'd5, 16'h2345};

        // Reset with inputs toggling
        clearn = 1'b0;
        tecladoNum = 10'b00_1000_0000;
        enable = 1'b1;
        tick_sample();
        @(negedge clock);
        tecladoNum = 10'b00_0000_0100;
        enable = 1'b0;
        tick_sample();
        chk("reset_d", 32'(d), 32'd0);
        chk("reset_loadn", 32'(loadn), 32'd1);
        chk("reset_digits", 32'(digits), 32'd0);
        chk("reset_key_err", 32'(key_err), 32'd0);
        chk("reset_pgt", 32'(pgt_1hz), 32'd0);
        @(negedge clock);
        clearn = 1'b1;
        tecladoNum = '0;
        count_cycles(4);

        // Key 7: exact strobe latency, pgt one cycle later, no repeat while held
        @(negedge clock);
        tecladoNum = 10'b00_1000_0000;
        loads = 0;
        pgts = 0;
        for (int i = 1; i <= 60; i++) begin
            tick_sample();
            if (loadn !== ((i == 6) ? 1'b0 : 1'b1)) begin
                chk($sformatf("key7_loadn_c%0d", i), 32'(loadn), (i == 6) ? 32'd0 : 32'd1);
            end
            if (pgt_1hz !== ((i == 7) ? 1'b1 : 1'b0)) begin
                chk($sformatf("key7_pgt_c%0d", i), 32'(pgt_1hz), (i == 7) ? 32'd1 : 32'd0);
            end
            if (loadn === 1'b0) loads++;
            if (pgt_1hz === 1'b1) pgts++;
            if (i == 6) begin
                chk("key7_loadn_at_6", 32'(loadn), 32'd0);
                chk("key7_d", 32'(d), 32'd7);
                chk("key7_digits", 32'(digits), 32'h0007);
            end
        end
        chk("key7_loads_total", 32'(loads), 32'd1);
        chk("key7_pgts_total", 32'(pgts), 32'd1);
        @(negedge clock);
        tecladoNum = '0;
        count_cycles(4);

        // Table-driven presses
        for (int t = 0; t < 6; t++) begin
            loads = 0;
            errs = 0;
            pgts = 0;
            @(negedge clock);
            tecladoNum = tbl[t].key;
            count_cycles(tbl[t].hold);
            @(negedge clock);
            tecladoNum = '0;
            count_cycles(tbl[t].gap);
            chk($sformatf("tbl%0d_loads", t), 32'(loads), 32'(tbl[t].exp_loads));
            chk($sformatf("tbl%0d_errs", t), 32'(errs), 32'(tbl[t].exp_errs));
            chk($sformatf("tbl%0d_pgts", t), 32'(pgts), 32'(tbl[t].exp_pgts));
            chk($sformatf("tbl%0d_d", t), 32'(d), 32'(tbl[t].exp_d));
            chk($sformatf("tbl%0d_digits", t), 32'(digits), 32'(tbl[t].exp_digits));
        end

        // Bounce on key 3, then stable
        loads = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            tecladoNum = (((i / 2) % 2) == 0) ? 10'b00_0000_1000 : 10'b0;
            count_cycles(1);
        end
        chk("bounce_no_early_load", 32'(loads), 32'd0);
        @(negedge clock);
        tecladoNum = 10'b00_0000_1000;
        count_cycles(10);
        @(negedge clock);
        tecladoNum = '0;
        count_cycles(4);
        chk("bounce_loads", 32'(loads), 32'd1);
        chk("bounce_d", 32'(d), 32'd3);
        chk("bounce_digits", 32'(digits), 32'h3453);

        // Cooking: divider ticks every 100 cycles, keys ignored
        loads = 0;
        for (int i = 1; i <= 350; i++) begin
            @(negedge clock);
            enable = 1'b1;
            tecladoNum = (i >= 150 && i < 200) ? 10'b00_0001_0000 : 10'b0;
            tick_sample();
            if (loadn === 1'b0) loads++;
            if ((i % 100 == 0) || (pgt_1hz !== 1'b0)) begin
                chk($sformatf("run1_pgt_c%0d", i), 32'(pgt_1hz), (i % 100 == 0) ? 32'd1 : 32'd0);
            end
        end
        chk("run1_no_load", 32'(loads), 32'd0);
        chk("run1_d_held", 32'(d), 32'd3);
        chk("run1_digits_held", 32'(digits), 32'h3453);

        @(negedge clock);
        enable = 1'b0;
        pgts = 0;
        count_cycles(20);
        chk("idle_pgts", 32'(pgts), 32'd0);

        // Re-enable: divider restarts from zero
        for (int i = 1; i <= 120; i++) begin
            @(negedge clock);
            enable = 1'b1;
            tick_sample();
            if ((i == 100) || (pgt_1hz !== 1'b0)) begin
                chk($sformatf("run2_pgt_c%0d", i), 32'(pgt_1hz), (i == 100) ? 32'd1 : 32'd0);
            end
        end
        @(negedge clock);
        enable = 1'b0;
        count_cycles(3);

        // Reset mid-press: held key re-debounced from scratch
        @(negedge clock);
        tecladoNum = 10'b10_0000_0000;
        count_cycles(3);
        @(negedge clock);
        clearn = 1'b0;
        tick_sample();
        chk("midrst_digits", 32'(digits), 32'd0);
        chk("midrst_loadn", 32'(loadn), 32'd1);
        @(negedge clock);
        clearn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick_sample();
            if ((i == 6) || (loadn !== 1'b1)) begin
                chk($sformatf("midrst_loadn_c%0d", i), 32'(loadn), (i == 6) ? 32'd0 : 32'd1);
            end
        end
        @(negedge clock);
        tecladoNum = '0;
        count_cycles(4);
        chk("midrst_d", 32'(d), 32'd9);
        chk("midrst_digits_after", 32'(digits), 32'h0009);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
